mem_share_mp: RTL

Parametrised N-port shared memory that replaces the fixed two-port host/client `memory_share` between beta CPUs and the camera FSM. Any number of requesters (betas, camera, future DMA) share one single-ported word array through a round-robin arbiter with a req/ack handshake. A built-in doorbell register raises per-port interrupt lines so one CPU can signal another that a shared buffer is ready. It sits between each requester's address decode (`sel_*_shared`) and its read mux.

---
 rtl/mem_share_pkg.sv | 30 +++
 rtl/mem_share_mp_rr_arbiter.sv | 31 +++
 rtl/mem_share_mp.sv | 112 +++++++++++
 3 files changed

// File: rtl/mem_share_pkg.sv
// Shared-memory address map constants, region decode and parameter legality helper.
// Pure definitions, no logic; imported by the shared-memory top and its address decoders.
package mem_share_pkg;

   localparam int unsigned DB_SET_OFS = 0;
   localparam int unsigned DB_CLR_OFS = 1;

   typedef enum logic [1:0] {
      RGN_RAM,
      RGN_DB_SET,
      RGN_DB_CLR,
      RGN_NONE
   } region_e;

   // The word address space must reach the two doorbell registers above the RAM.
   function automatic bit aw_legal(input int unsigned aw, input int unsigned depth);
      return (longint'(1) << aw) >= (longint'(depth) + 2);
   endfunction

   function automatic region_e decode_region(input int unsigned a, input int unsigned depth);
      if (a < depth)
         return RGN_RAM;
      if (a == depth + DB_SET_OFS)
         return RGN_DB_SET;
      if (a == depth + DB_CLR_OFS)
         return RGN_DB_CLR;
      return RGN_NONE;
   endfunction

endpackage

// File: rtl/mem_share_mp_rr_arbiter.sv
// Round-robin arbiter: first eligible requester searching upward from last+1, modulo N.
// Combinational, zero latency; no backpressure, caller decides when last advances.
module rr_arbiter #(
   parameter int N  = 3,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  eligible,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          any
);

   logic [IW-1:0] cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      cand      = '0;
      for (int off = 1; off <= N; off++) begin
         cand = IW'((int'(last) + off) % N);
         if (!any && eligible[cand]) begin
            any         = 1'b1;
            grant_idx   = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_share_mp.sv
// N-port round-robin shared word memory with a doorbell register driving per-port irq lines.
// Uncontended access acks one cycle after req; contended requesters hold req until their ack.
module mem_share_mp
   import mem_share_pkg::*;
#(
   parameter int N_PORTS = 3,
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 1024,
   parameter int AW      = 11
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_PORTS-1:0]         req,
   input  logic [N_PORTS-1:0]         we,
   input  logic [N_PORTS*AW-1:0]      addr,
   input  logic [N_PORTS*WIDTH-1:0]   din,
   output logic [N_PORTS-1:0]         ack,
   output logic [N_PORTS*WIDTH-1:0]   dout,
   output logic [N_PORTS-1:0]         irq
);

   localparam int IW = $clog2(N_PORTS);
   localparam int MW = $clog2(DEPTH);

   if (N_PORTS < 2 || N_PORTS > 8) begin : g_bad_nports
      $error("mem_share_mp: N_PORTS must be 2..8");
   end
   if (!aw_legal(AW, DEPTH)) begin : g_bad_aw
      $error("mem_share_mp: AW too narrow for DEPTH plus doorbell registers");
   end

   logic [AW-1:0]    addr_a [N_PORTS];
   logic [WIDTH-1:0] din_a  [N_PORTS];
   logic [WIDTH-1:0] dout_q [N_PORTS];

   for (genvar k = 0; k < N_PORTS; k++) begin : g_port
      assign addr_a[k]                 = addr[k*AW +: AW];
      assign din_a[k]                  = din[k*WIDTH +: WIDTH];
      assign dout[k*WIDTH +: WIDTH]    = dout_q[k];
   end

   logic [N_PORTS-1:0] eligible;
   logic [N_PORTS-1:0] grant;
   logic [IW-1:0]      grant_idx;
   logic [IW-1:0]      last;
   logic               any;

   // A port in its ack cycle sits out, so a held req is never serviced twice.
   assign eligible = req & ~ack;

   rr_arbiter #(
      .N  (N_PORTS),
      .IW (IW)
   ) u_arb (
      .eligible  (eligible),
      .last      (last),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any       (any)
   );

   logic [AW-1:0]    g_addr;
   logic [WIDTH-1:0] g_din;
   logic             g_we;
   region_e          rgn;

   assign g_addr = addr_a[grant_idx];
   assign g_din  = din_a[grant_idx];
   assign g_we   = we[grant_idx];
   assign rgn    = decode_region(32'(g_addr), DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_val;

   always_ff @(posedge clk) begin
      if (any && g_we && rgn == RGN_RAM)
         mem[g_addr[MW-1:0]] <= g_din;
   end

   always_comb begin
      rd_val = '0;
      case (rgn)
         RGN_RAM:                rd_val = mem[g_addr[MW-1:0]];
         RGN_DB_SET, RGN_DB_CLR: rd_val = WIDTH'(irq);
         default:                rd_val = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ack  <= '0;
         irq  <= '0;
         last <= IW'(N_PORTS - 1);
         for (int k = 0; k < N_PORTS; k++)
            dout_q[k] <= '0;
      end else begin
         ack <= grant;
         if (any) begin
            last <= grant_idx;
            if (g_we) begin
               if (rgn == RGN_DB_SET)
                  irq <= irq | g_din[N_PORTS-1:0];
               else if (rgn == RGN_DB_CLR)
                  irq <= irq & ~g_din[N_PORTS-1:0];
            end else begin
               dout_q[grant_idx] <= rd_val;
            end
         end
      end
   end

endmodule
